execute_mul_ctrl: RTL and testbench

//  Multi-cycle MUL sequencer for the execute stage of the 64-bit LEGv8 pipeline.
//  On a MUL in EX it takes ownership of the execute ALU and runs shift-add

---
 rtl/execute_mul_ctrl.sv | 146 ++++++++++++++
 tb/tb_execute_mul_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_mul_ctrl.sv
// Multi-cycle shift-add MUL sequencer for the LEGv8 execute stage.
// Borrows the execute ALU for the partial-product adds and stalls the pipeline
// until the low N bits of the product are ready.
//
//   state | meaning
//   IDLE  | ALU under pipeline control; stall follows start_i
//   ITER  | one shift-add step per cycle, ALU owned, pipeline stalled
//   DONE  | product_o valid, done_o pulse, MUL retires
module execute_mul_ctrl #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic [N-1:0] opA_i,
    input  logic [N-1:0] opB_i,
    input  logic [N-1:0] aluResult_i,
    output logic         alu_own_o,
    output logic [N-1:0] alu_a_o,
    output logic [N-1:0] alu_b_o,
    output logic [3:0]   alu_ctrl_o,
    output logic         stall_o,
    output logic         done_o,
    output logic [N-1:0] product_o
);

    localparam int          CW       = $clog2(N);
    localparam logic [3:0]  ALU_ADD  = 4'b0010;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   acc;
    logic [N-1:0]   mcand;
    logic [N-1:0]   mplier;
    logic [N-1:0]   product_q;
    logic [CW-1:0]  count;
    logic           last_iter;
    logic [N-1:0]   acc_next;

    // Stop as soon as no multiplier bits remain above the one consumed this cycle.
    assign last_iter = ((mplier >> 1) == '0) || (count == CNT_LAST);
    assign acc_next  = mplier[0] ? aluResult_i : acc;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start_i only matters in IDLE so a stale start in DONE cannot retrigger
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_nxt = (opB_i == '0) ? S_DONE : S_ITER;
                end
            end
            S_ITER: begin
                if (last_iter) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode; the ALU is only driven in ITER
    always_comb begin
        alu_own_o  = 1'b0;
        alu_a_o    = '0;
        alu_b_o    = '0;
        alu_ctrl_o = 4'b0000;
        stall_o    = 1'b0;
        done_o     = 1'b0;
        case (state)
            S_IDLE: begin
                stall_o = start_i;
            end
            S_ITER: begin
                alu_own_o  = 1'b1;
                alu_a_o    = acc;
                alu_b_o    = mcand;
                alu_ctrl_o = ALU_ADD;
                stall_o    = 1'b1;
            end
            S_DONE: begin
                done_o = 1'b1;
            end
            default: begin
                stall_o = 1'b0;
            end
        endcase
    end

    // Shift-add datapath; product captures the final accumulator on the edge into DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            count     <= '0;
            product_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        mcand  <= opA_i;
                        mplier <= opB_i;
                        acc    <= '0;
                        count  <= '0;
                        if (opB_i == '0) begin
                            product_q <= '0;
                        end
                    end
                end
                S_ITER: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (last_iter) begin
                        product_q <= acc_next;
                    end
                end
                default: begin
                    acc <= acc;
                end
            endcase
        end
    end

    assign product_o = product_q;

endmodule

// File: tb/tb_execute_mul_ctrl.sv
// Self-checking bench for execute_mul_ctrl: transaction-level reference model
// plus directed literal cases and randomized operand/start traffic.
module tb_execute_mul_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] opa;
    logic [63:0] opb;
    logic [63:0] alu_result;
    logic [63:0] junk;
    logic        alu_own;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic        stall;
    logic        done;
    logic [63:0] product;

    int n_chk  = 0;
    int n_fail = 0;

    execute_mul_ctrl #(.N(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start),
        .opA_i       (opa),
        .opB_i       (opb),
        .aluResult_i (alu_result),
        .alu_own_o   (alu_own),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_ctrl_o  (alu_ctrl),
        .stall_o     (stall),
        .done_o      (done),
        .product_o   (product)
    );

    // Execute ALU stand-in: adds when owned, otherwise returns unrelated pipeline data.
    assign alu_result = alu_own ? (alu_a + alu_b) : junk;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int msb_idx(input logic [63:0] v);
        for (int i = 63; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Reference model: phase 0 idle, 1 iterating (step m_k of m_iters), 2 done.
    int          m_phase = 0;
    int          m_k     = 0;
    int          m_iters = 0;
    logic [63:0] m_a     = '0;
    logic [63:0] m_b     = '0;
    logic [63:0] m_held  = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase <= 0;
            m_k     <= 0;
            m_held  <= '0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_a <= opa;
                    m_b <= opb;
                    m_k <= 0;
                    if (opb == 64'd0) begin
                        m_phase <= 2;
                        m_held  <= 64'd0;
                    end else begin
                        m_iters <= msb_idx(opb) + 1;
                        m_phase <= 1;
                    end
                end
                1: begin
                    m_k <= m_k + 1;
                    if (m_k + 1 == m_iters) begin
                        m_phase <= 2;
                        m_held  <= m_a * m_b;
                    end
                end
                default: m_phase <= 0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model; called at the falling edge.
    task automatic compare_model();
        logic        e_own;
        logic [63:0] mask;
        e_own = (m_phase == 1);
        mask  = (64'd1 << m_k) - 64'd1;
        chk("alu_own", alu_own, e_own);
        chk("stall", stall, e_own || (m_phase == 0 && start));
        chk("done", done, m_phase == 2);
        chk("alu_ctrl", alu_ctrl, e_own ? 64'd2 : 64'd0);
        chk("alu_a", alu_a, e_own ? m_a * (m_b & mask) : 64'd0);
        chk("alu_b", alu_b, e_own ? (m_a << m_k) : 64'd0);
        chk("product", product, m_held);
    endtask

    task automatic sample_cycle();
        @(negedge clk);
        compare_model();
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        junk = {$urandom, $urandom};
    endtask

    // One MUL: start for one cycle (or held through DONE), report observed counts.
    task automatic run_mul(input logic [63:0] a, input logic [63:0] b, input bit hold,
                           output int n_own, output int n_stall, output int n_cyc,
                           output int n_extra_done, output logic [63:0] prod);
        bit got;
        bit saw;
        n_own = 0; n_stall = 0; n_cyc = 0; n_extra_done = 0; prod = 'x; got = 0;
        start = 1'b1; opa = a; opb = b;
        for (int c = 0; c < 100; c++) begin
            sample_cycle();
            n_cyc++;
            if (alu_own) n_own++;
            if (stall) n_stall++;
            saw = done;
            if (done) prod = product;
            next_cycle();
            if (!hold || saw) start = 1'b0;
            if (saw) begin
                got = 1;
                break;
            end
        end
        chk("done_timeout", {63'd0, got}, 64'd1);
        for (int c = 0; c < 4; c++) begin
            sample_cycle();
            if (done) n_extra_done++;
            next_cycle();
        end
    endtask

    int          own_c, stall_c, cyc_c, extra_c, rand_dones;
    logic [63:0] prod_c;

    initial begin
        reset = 1'b0; start = 1'b0; opa = '0; opb = '0; junk = '0;
        sample_cycle();
        chk("rst_own", alu_own, 64'd0);
        chk("rst_stall", stall, 64'd0);
        chk("rst_done", done, 64'd0);
        chk("rst_product", product, 64'd0);
        next_cycle();
        reset = 1'b1;
        next_cycle();

        // 1: 0xE * 0xA
        run_mul(64'hE, 64'hA, 0, own_c, stall_c, cyc_c, extra_c, prod_c);
        chk("t1_iter", own_c, 64'd4);
        chk("t1_product", prod_c, 64'h8C);
        chk("t1_cycles", cyc_c, 64'd6);

        // 2: 3 * 5
        run_mul(64'd3, 64'd5, 0, own_c, stall_c, cyc_c, extra_c, prod_c);
        chk("t2_stall", stall_c, 64'd4);
        chk("t2_done_cycle", cyc_c, 64'd5);
        chk("t2_product", prod_c, 64'hF);

        // 3: multiplier zero
        run_mul(64'h1234, 64'd0, 0, own_c, stall_c, cyc_c, extra_c, prod_c);
        chk("t3_own", own_c, 64'd0);
        chk("t3_done_cycle", cyc_c, 64'd2);
        chk("t3_product", prod_c, 64'd0);

        // 4: all ones squared
        run_mul('1, '1, 0, own_c, stall_c, cyc_c, extra_c, prod_c);
        chk("t4_iter", own_c, 64'd64);
        chk("t4_product", prod_c, 64'h1);

        // 5: reset during the second ITER cycle of test 1
        start = 1'b1; opa = 64'hE; opb = 64'hA;
        sample_cycle();
        next_cycle();
        start = 1'b0;
        sample_cycle();
        next_cycle();
        #2 reset = 1'b0;
        #1;
        chk("t5_own", alu_own, 64'd0);
        chk("t5_stall", stall, 64'd0);
        chk("t5_alu_a", alu_a, 64'd0);
        chk("t5_ctrl", alu_ctrl, 64'd0);
        chk("t5_product", product, 64'd0);
        sample_cycle();
        next_cycle();
        reset = 1'b1;
        extra_c = 0;
        for (int c = 0; c < 6; c++) begin
            sample_cycle();
            if (done) extra_c++;
            next_cycle();
        end
        chk("t5_no_done", extra_c, 64'd0);
        run_mul(64'hE, 64'hA, 0, own_c, stall_c, cyc_c, extra_c, prod_c);
        chk("t5_recover", prod_c, 64'h8C);

        // 6: start held through DONE must not retrigger
        run_mul(64'd3, 64'd5, 1, own_c, stall_c, cyc_c, extra_c, prod_c);
        chk("t6_product", prod_c, 64'hF);
        chk("t6_extra_done", extra_c, 64'd0);
        chk("t6_idle_own", alu_own, 64'd0);
        run_mul(64'd7, 64'd9, 0, own_c, stall_c, cyc_c, extra_c, prod_c);
        chk("t6_fresh", prod_c, 64'd63);

        // Random traffic
        rand_dones = 0;
        for (int c = 0; c < 2500; c++) begin
            start = ($urandom_range(0, 2) == 0);
            opa   = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       opb = 64'd0;
                1:       opb = 64'($urandom_range(0, 15));
                2:       opb = {$urandom, $urandom};
                default: opb = {$urandom, $urandom} >> $urandom_range(0, 63);
            endcase
            sample_cycle();
            if (done) rand_dones++;
            next_cycle();
        end
        start = 1'b0;
        chk("rand_activity", {63'd0, rand_dones > 20}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
